// File: rtl/ex_mem.sv
// EX/MEM pipeline register: registers execute results, applies stall/bubble, and returns
// the multi-cycle hilo/cnt intermediate to execute. Optional flush port via EX_MEM_FLUSH_EN.
module ex_mem #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int STALL_W = 6,
  parameter int EX_IDX  = 3,
  parameter int MEM_IDX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef EX_MEM_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic [STALL_W-1:0]    stall,
  input  logic [ADDR_W-1:0]     ex_waddr,
  input  logic                  ex_wreg,
  input  logic [DATA_W-1:0]     ex_wdata,
  input  logic [DATA_W-1:0]     ex_hi,
  input  logic [DATA_W-1:0]     ex_lo,
  input  logic                  ex_whilo,
  input  logic [2*DATA_W-1:0]   hilo_i,
  input  logic [1:0]            cnt_i,
  output logic [ADDR_W-1:0]     mem_waddr,
  output logic                  mem_wreg,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W-1:0]     mem_hi,
  output logic [DATA_W-1:0]     mem_lo,
  output logic                  mem_whilo,
  output logic [2*DATA_W-1:0]   hilo_o,
  output logic [1:0]            cnt_o
);

  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic                wreg_q,  wreg_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   hi_q,    hi_d;
  logic [DATA_W-1:0]   lo_q,    lo_d;
  logic                whilo_q, whilo_d;
  logic [2*DATA_W-1:0] hilo_q,  hilo_d;
  logic [1:0]          cnt_q,   cnt_d;
  logic                flush_w;

`ifdef EX_MEM_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // Default is Hold: mem_* keep their value while the intermediate follows execute.
  // A memory-only stall (illegal) falls into the Advance branch.
  always_comb begin
    waddr_d = waddr_q;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    whilo_d = whilo_q;
    hilo_d  = hilo_i;
    cnt_d   = cnt_i;
    if (flush_w) begin
      waddr_d = '0;
      wreg_d  = 1'b0;
      wdata_d = '0;
      hi_d    = '0;
      lo_d    = '0;
      whilo_d = 1'b0;
      hilo_d  = '0;
      cnt_d   = '0;
    end else if (!stall[EX_IDX]) begin
      waddr_d = ex_waddr;
      wreg_d  = ex_wreg;
      wdata_d = ex_wdata;
      hi_d    = ex_hi;
      lo_d    = ex_lo;
      whilo_d = ex_whilo;
      hilo_d  = '0;
      cnt_d   = '0;
    end else if (!stall[MEM_IDX]) begin
      waddr_d = '0;
      wreg_d  = 1'b0;
      wdata_d = '0;
      hi_d    = '0;
      lo_d    = '0;
      whilo_d = 1'b0;
    end
  end

  // EX -> MEM stage boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      waddr_q <= '0;
      wreg_q  <= 1'b0;
      wdata_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      whilo_q <= 1'b0;
      hilo_q  <= '0;
      cnt_q   <= '0;
    end else begin
      waddr_q <= waddr_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      whilo_q <= whilo_d;
      hilo_q  <= hilo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_waddr = waddr_q;
  assign mem_wreg  = wreg_q;
  assign mem_wdata = wdata_q;
  assign mem_hi    = hi_q;
  assign mem_lo    = lo_q;
  assign mem_whilo = whilo_q;
  assign hilo_o    = hilo_q;
  assign cnt_o     = cnt_q;

endmodule

// File: doc/ex_mem.md
Name: ex_mem

Overview:
- Pipeline register between the execute stage and the memory-access stage of the 5-stage MIPS32 core.
- Registers the execute results: GPR writeback address, enable and data, plus HI/LO write data and enable.
- Applies the core's global stall bus and inserts a bubble when execute stalls but memory does not.
- Carries the 64-bit multiply-accumulate intermediate (hilo) and its 2-bit cycle count back to execute across stalls, so MADD/MSUB-style multi-cycle ops resume correctly.

Parameters:
- DATA_W, 32, GPR/HI/LO data width
- ADDR_W, 5, GPR address width
- STALL_W, 6, width of global stall bus (pc, if, id, ex, mem, wb)
- EX_IDX, 3, stall bit index of execute stage
- MEM_IDX, 4, stall bit index of memory stage

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high (RstEnable = 1'b1)
- stall  in  STALL_W  global stall bus; bit=1 means stage held
- ex_waddr  in  ADDR_W  execute-stage destination GPR
- ex_wreg  in  1  execute-stage GPR write enable
- ex_wdata  in  DATA_W  execute-stage result
- ex_hi  in  DATA_W  HI write data
- ex_lo  in  DATA_W  LO write data
- ex_whilo  in  1  HI/LO write enable
- hilo_i  in  2*DATA_W  multi-cycle intermediate from execute
- cnt_i  in  2  multi-cycle step count from execute
- mem_waddr  out  ADDR_W  registered destination GPR
- mem_wreg  out  1  registered GPR write enable
- mem_wdata  out  DATA_W  registered result
- mem_hi  out  DATA_W  registered HI data
- mem_lo  out  DATA_W  registered LO data
- mem_whilo  out  1  registered HI/LO write enable
- hilo_o  out  2*DATA_W  intermediate returned to execute
- cnt_o  out  2  step count returned to execute

Behaviour:
- Latency: 1 cycle, input to mem_* output.
- Each rising edge evaluates the following in priority order (first match wins):
- 1. rst=1:
  - All mem_* outputs <= 0, hilo_o <= 0, cnt_o <= 0.
  - Reset mid-stall or mid-multi-cycle discards the intermediate.
- 2. Bubble (stall[EX_IDX]=1 and stall[MEM_IDX]=0):
  - All mem_* outputs <= 0 (NOP: wreg=0, whilo=0, waddr=0, data=0).
  - hilo_o <= hilo_i, cnt_o <= cnt_i (intermediate preserved for the resuming op).
- 3. Advance (stall[EX_IDX]=0):
  - All mem_* <= corresponding ex_* inputs.
  - hilo_o <= 0, cnt_o <= 0 (multi-cycle op completed).
- 4. Hold (stall[EX_IDX]=1 and stall[MEM_IDX]=1):
  - All mem_* keep their current value.
  - hilo_o <= hilo_i, cnt_o <= cnt_i.
- stall[EX_IDX]=0 with stall[MEM_IDX]=1 is illegal (the controller never stalls downstream alone). The register treats it as Advance.
- No combinational path from any input to any output.
- cnt is a 2-bit value passed through, not interpreted; cnt_i=2'b11 is passed through unchanged.
- Enables and data are registered together, so mem_wreg=0 always pairs with a consistent bubble.

Optional Feature:
- Macro EX_MEM_FLUSH_EN.
- When defined:
  - Adds input port flush (1 bit), active-high, synchronous.
  - Priority is below rst and above all stall cases.
  - flush=1 forces all mem_* <= 0, hilo_o <= 0, cnt_o <= 0 regardless of stall; used for exception/eret pipeline flush.
- When undefined:
  - No flush port.
  - Behaviour is exactly the four cases above.

Test Plan:
- Reset: rst=1 for 2 cycles with ex_wreg=1, ex_wdata=32'hDEADBEEF -> all outputs 0. The cycle after rst falls with stall=0, mem_wdata=32'hDEADBEEF, mem_wreg=1.
- Pass-through: stall=6'b000000; ex_waddr=5'd7, ex_wdata=32'h12345678, ex_whilo=1, ex_hi=32'hA, ex_lo=32'hB -> next cycle mem_* match exactly; hilo_o=0, cnt_o=0.
- Bubble with intermediate: stall=6'b001111, hilo_i=64'h0000_0001_FFFF_FFFE, cnt_i=2'b01, ex_wreg=1 -> mem_wreg=0, mem_whilo=0, mem_wdata=0; hilo_o=64'h0000_0001_FFFF_FFFE, cnt_o=2'b01.
- Hold: load mem_wdata=32'h55 with stall=0, then stall=6'b011111 for 3 cycles with ex_wdata=32'hAA -> mem_wdata stays 32'h55; hilo_o/cnt_o track hilo_i/cnt_i each cycle.
- Completion: after the bubble case, drop stall to 0 with cnt_i=2'b10 -> next cycle hilo_o=0, cnt_o=0, and mem_* carry the ex_* values.
- Flush (EX_MEM_FLUSH_EN defined): mem_wreg=1 loaded, then flush=1 with stall=6'b011111 -> next cycle all outputs 0. With rst=1 and flush=1 together -> all outputs 0.
